// File: rtl/stage2_cnn_pkg.sv
// ============================================================================
// stage2_cnn_pkg : shared width helpers, saturation limits and stage tag type
// Revision: 1.0
// ============================================================================
`default_nettype none

package stage2_cnn_pkg;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_tag_t;

  localparam int SAT_LIMIT_W = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int mbw(input int ibw, input int wbw);
    return ibw + wbw;
  endfunction

  function automatic int akbw(input int mbw_v, input int n_terms);
    return mbw_v + clog2(n_terms);
  endfunction

  function automatic int accbw(input int akbw_v, input int ch);
    return akbw_v + clog2(ch);
  endfunction

  function automatic logic signed [SAT_LIMIT_W-1:0] sat_max(input int obw);
    return (64'sd1 <<< (obw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [SAT_LIMIT_W-1:0] sat_min(input int obw);
    return -(64'sd1 <<< (obw - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/stage2_cnn_adder_tree.sv
// ============================================================================
// stage2_cnn_adder_tree : two registered levels, row sums then their total
// Revision: 1.0
// ============================================================================
`default_nettype none

module stage2_cnn_adder_tree
  import stage2_cnn_pkg::*;
#(
  parameter int N       = 25,
  parameter int IBW     = 28,
  parameter int ROW_LEN = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_en,
  input  logic [N*IBW-1:0]                i_data,
  output logic signed [IBW+clog2(N)-1:0]  o_sum
);

  localparam int c_obw  = IBW + clog2(N);
  localparam int c_rows = (N + ROW_LEN - 1) / ROW_LEN;

  logic signed [c_obw-1:0] w_row_sum [c_rows];
  logic signed [c_obw-1:0] r_row_sum [c_rows];
  logic signed [c_obw-1:0] w_total;

  always_comb begin
    for (int r = 0; r < c_rows; r++) begin
      w_row_sum[r] = '0;
      for (int j = 0; j < ROW_LEN; j++) begin
        if (r * ROW_LEN + j < N)
          w_row_sum[r] = w_row_sum[r] + c_obw'($signed(i_data[(r*ROW_LEN+j)*IBW +: IBW]));
      end
    end
  end

  always_comb begin
    w_total = '0;
    for (int r = 0; r < c_rows; r++) w_total = w_total + r_row_sum[r];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < c_rows; r++) r_row_sum[r] <= '0;
      o_sum <= '0;
    end else if (i_en) begin
      for (int r = 0; r < c_rows; r++) r_row_sum[r] <= w_row_sum[r];
      o_sum <= w_total;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stage2_cnn_kernel_mc.sv
// ============================================================================
// stage2_cnn_kernel_mc : multi-channel KXxKY convolution kernel, 4-stage pipe
// Optional build macro STAGE2_KERNEL_SAT_EN saturates o_ot_acc on overflow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stage2_cnn_kernel_mc
  import stage2_cnn_pkg::*;
#(
  parameter int KX  = 5,
  parameter int KY  = 5,
  parameter int IBW = 20,
  parameter int WBW = 8,
  parameter int CH  = 3,
  parameter int OBW = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [KX*KY*IBW-1:0]    i_in_fmap,
  input  logic [KX*KY*WBW-1:0]    i_cnn_weight,
  output logic                    o_ot_valid,
  input  logic                    i_ot_ready,
  output logic [OBW-1:0]          o_ot_acc,
  output logic                    o_ot_ovf
);

  localparam int c_n     = KX * KY;
  localparam int c_mbw   = mbw(IBW, WBW);
  localparam int c_akbw  = akbw(c_mbw, c_n);
  localparam int c_accbw = accbw(c_akbw, CH);
  localparam int c_cntw  = (CH > 1) ? clog2(CH) : 1;

  logic                     w_en;
  logic                     w_last;
  logic [c_cntw-1:0]        r_chan_cnt;
  logic [c_n*c_mbw-1:0]     w_prod;
  logic [c_n*c_mbw-1:0]     r_prod;
  beat_tag_t                r_s1_tag, r_s2_tag, r_s3_tag;
  logic signed [c_akbw-1:0] w_tree_sum;
  logic signed [c_accbw-1:0] r_acc, w_acc_next, w_kernel_ext;
  logic [OBW-1:0]           w_out;
  logic                     w_ovf;

  // Whole pipe stalls only when a finished result is waiting on downstream.
  assign w_en       = !o_ot_valid || i_ot_ready;
  assign o_in_ready = w_en;
  assign w_last     = (r_chan_cnt == c_cntw'(CH - 1));

  for (genvar k = 0; k < c_n; k++) begin : g_mul
    logic signed [c_mbw-1:0] w_a, w_b;
    assign w_a = c_mbw'($signed(i_in_fmap[k*IBW +: IBW]));
    assign w_b = c_mbw'($signed(i_cnn_weight[k*WBW +: WBW]));
    assign w_prod[k*c_mbw +: c_mbw] = w_a * w_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod     <= '0;
      r_s1_tag   <= '0;
      r_chan_cnt <= '0;
    end else if (w_en) begin
      r_prod         <= w_prod;
      r_s1_tag.valid <= i_in_valid;
      r_s1_tag.first <= (r_chan_cnt == '0);
      r_s1_tag.last  <= w_last;
      if (i_in_valid)
        r_chan_cnt <= w_last ? '0 : r_chan_cnt + c_cntw'(1);
    end
  end

  stage2_cnn_adder_tree #(
    .N       (c_n),
    .IBW     (c_mbw),
    .ROW_LEN (KX)
  ) u_tree (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_en),
    .i_data (r_prod),
    .o_sum  (w_tree_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_tag <= '0;
      r_s3_tag <= '0;
    end else if (w_en) begin
      r_s2_tag <= r_s1_tag;
      r_s3_tag <= r_s2_tag;
    end
  end

  assign w_kernel_ext = c_accbw'(w_tree_sum);
  assign w_acc_next   = r_s3_tag.first ? w_kernel_ext : r_acc + w_kernel_ext;

  if (OBW < c_accbw) begin : g_narrow
    localparam logic signed [c_accbw-1:0] c_max = c_accbw'(sat_max(OBW));
    localparam logic signed [c_accbw-1:0] c_min = c_accbw'(sat_min(OBW));
    assign w_ovf = (w_acc_next > c_max) || (w_acc_next < c_min);
`ifdef STAGE2_KERNEL_SAT_EN
    assign w_out = !w_ovf ? w_acc_next[OBW-1:0]
                          : (w_acc_next[c_accbw-1] ? c_min[OBW-1:0] : c_max[OBW-1:0]);
`else
    assign w_out = w_acc_next[OBW-1:0];
`endif
  end else begin : g_wide
    assign w_ovf = 1'b0;
    assign w_out = OBW'(w_acc_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      o_ot_valid <= 1'b0;
      o_ot_acc   <= '0;
      o_ot_ovf   <= 1'b0;
    end else if (w_en) begin
      if (r_s3_tag.valid) r_acc <= w_acc_next;
      o_ot_valid <= r_s3_tag.valid && r_s3_tag.last;
      if (r_s3_tag.valid && r_s3_tag.last) begin
        o_ot_acc <= w_out;
        o_ot_ovf <= w_ovf;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stage2_cnn_kernel_mc.sv
// ============================================================================
// tb_stage2_cnn_kernel_mc : self-checking bench for stage2_cnn_kernel_mc
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stage2_cnn_kernel_mc;

  localparam int N   = 25;
  localparam int IBW = 20;
  localparam int WBW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [N*IBW-1:0] fmap;
  logic [N*WBW-1:0] weight;
  logic             in_valid [3];
  logic             in_ready [3];
  logic             ot_valid [3];
  logic             ot_ready [3];
  logic             ot_ovf   [3];
  logic [31:0]      acc0, acc2;
  logic [15:0]      acc1;
  longint           ot_acc   [3];

  always_comb begin
    ot_acc[0] = longint'($signed(acc0));
    ot_acc[1] = longint'($signed(acc1));
    ot_acc[2] = longint'($signed(acc2));
  end

  stage2_cnn_kernel_mc u_dut0 (
    .clk(clk), .reset(reset), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
    .i_in_fmap(fmap), .i_cnn_weight(weight), .o_ot_valid(ot_valid[0]),
    .i_ot_ready(ot_ready[0]), .o_ot_acc(acc0), .o_ot_ovf(ot_ovf[0]));

  stage2_cnn_kernel_mc #(.OBW(16)) u_dut16 (
    .clk(clk), .reset(reset), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
    .i_in_fmap(fmap), .i_cnn_weight(weight), .o_ot_valid(ot_valid[1]),
    .i_ot_ready(ot_ready[1]), .o_ot_acc(acc1), .o_ot_ovf(ot_ovf[1]));

  stage2_cnn_kernel_mc #(.CH(1)) u_dut1 (
    .clk(clk), .reset(reset), .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]),
    .i_in_fmap(fmap), .i_cnn_weight(weight), .o_ot_valid(ot_valid[2]),
    .i_ot_ready(ot_ready[2]), .o_ot_acc(acc2), .o_ot_ovf(ot_ovf[2]));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int c_ch  [3] = '{3, 3, 1};
  int c_obw [3] = '{32, 16, 32};
  int m_ch  [3] = '{0, 0, 0};
  longint m_acc [3];

  longint exp_acc_q[$];
  bit     exp_ovf_q[$];
  longint got_acc_q[$];
  bit     got_ovf_q[$];
  int     lastcyc_q[$];
  int     gotcyc_q[$];

  function automatic longint dot(input logic [N*IBW-1:0] f, input logic [N*WBW-1:0] w);
    longint s;
    s = 0;
    for (int k = 0; k < N; k++)
      s += longint'($signed(f[k*IBW +: IBW])) * longint'($signed(w[k*WBW +: WBW]));
    return s;
  endfunction

  function automatic void expect_out(input longint s, input int obw, output longint a, output bit o);
    longint mx, mn;
    mx = (longint'(1) <<< (obw - 1)) - 1;
    mn = -mx - 1;
    o  = (s > mx) || (s < mn);
`ifdef STAGE2_KERNEL_SAT_EN
    a = o ? ((s > mx) ? mx : mn) : s;
`else
    a = (s <<< (64 - obw)) >>> (64 - obw);
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: sums channel dot products per frame and logs handshakes.
  always @(negedge clk) begin
    longint dp, ea;
    bit     eo;
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        m_ch[d] = 0;
      end else begin
        if (in_valid[d] && in_ready[d]) begin
          dp = dot(fmap, weight);
          m_acc[d] = (m_ch[d] == 0) ? dp : m_acc[d] + dp;
          if (m_ch[d] == c_ch[d] - 1) begin
            expect_out(m_acc[d], c_obw[d], ea, eo);
            exp_acc_q.push_back(ea);
            exp_ovf_q.push_back(eo);
            lastcyc_q.push_back(cyc);
            m_ch[d] = 0;
          end else begin
            m_ch[d]++;
          end
        end
        if (ot_valid[d] && ot_ready[d]) begin
          got_acc_q.push_back(ot_acc[d]);
          got_ovf_q.push_back(ot_ovf[d]);
          gotcyc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp_acc_q.delete(); exp_ovf_q.delete();
    got_acc_q.delete(); got_ovf_q.delete();
    lastcyc_q.delete(); gotcyc_q.delete();
  endtask

  task automatic set_all(input int f, input int w);
    for (int k = 0; k < N; k++) begin
      fmap[k*IBW +: IBW]   = IBW'(f);
      weight[k*WBW +: WBW] = WBW'(w);
    end
  endtask

  task automatic set_rand();
    for (int k = 0; k < N; k++) begin
      fmap[k*IBW +: IBW]   = IBW'($urandom);
      weight[k*WBW +: WBW] = WBW'($urandom);
    end
  endtask

  task automatic send(input int d);
    int n;
    bit hs;
    n = 0;
    in_valid[d] = 1'b1;
    #1;
    do begin
      hs = in_ready[d];
      step();
      n++;
    end while (!hs && n < 200);
    if (!hs) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout dut%0d: beat not accepted in 200 cycles", d);
    end
  endtask

  task automatic drain(input int d, input int n, input int budget);
    int k;
    in_valid[d] = 1'b0;
    k = 0;
    while (got_acc_q.size() < n && k < budget) begin
      step();
      k++;
    end
    n_tests++;
    if (got_acc_q.size() != n || exp_acc_q.size() != n) begin
      n_fail++;
      $display("FAIL drain_count dut%0d: got %0d results, model %0d, required %0d",
               d, got_acc_q.size(), exp_acc_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    for (int d = 0; d < 3; d++) begin
      n_tests += 4;
      if (ot_valid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_valid dut%0d: got %b required 0", d, ot_valid[d]); end
      if (ot_acc[d] !== 0)      begin n_fail++; $display("FAIL reset_acc dut%0d: got %0d required 0", d, ot_acc[d]); end
      if (ot_ovf[d] !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf dut%0d: got %b required 0", d, ot_ovf[d]); end
      if (in_ready[d] !== 1'b1) begin n_fail++; $display("FAIL reset_ready dut%0d: got %b required 1", d, in_ready[d]); end
    end
    reset = 1'b0;
    step();
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (in_ready[d] !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready dut%0d: got %b required 1", d, in_ready[d]); end
    end
  endtask

  task automatic test_ones();
    clear_q();
    set_all(1, 1);
    repeat (3) send(0);
    in_valid[0] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (i < 3) begin
        n_tests++;
        if (ot_valid[0] !== 1'b0) begin n_fail++; $display("FAIL ones_early_valid +%0d: got %b required 0", i, ot_valid[0]); end
      end
      step();
    end
    n_tests += 2;
    if (ot_valid[0] !== 1'b1) begin n_fail++; $display("FAIL ones_latency_valid: got %b required 1", ot_valid[0]); end
    if (ot_acc[0] !== 75)     begin n_fail++; $display("FAIL ones_acc: got %0d required 75", ot_acc[0]); end
    repeat (6) send(0);
    drain(0, 3, 20);
    for (int i = 0; i < got_acc_q.size() && i < 3; i++) begin
      n_tests += 2;
      if (got_acc_q[i] !== 75) begin n_fail++; $display("FAIL ones_result%0d: got %0d required 75", i, got_acc_q[i]); end
      if (gotcyc_q[i] - lastcyc_q[i] != 4) begin
        n_fail++; $display("FAIL ones_latency%0d: got %0d required 4", i, gotcyc_q[i] - lastcyc_q[i]);
      end
    end
    if (gotcyc_q.size() == 3) begin
      n_tests++;
      if (gotcyc_q[2] - gotcyc_q[1] != 3) begin
        n_fail++; $display("FAIL ones_spacing: got %0d required 3", gotcyc_q[2] - gotcyc_q[1]);
      end
    end
  endtask

  task automatic test_negative();
    clear_q();
    set_all(-2, 3);
    repeat (3) send(0);
    drain(0, 1, 20);
    if (got_acc_q.size() == 1) begin
      n_tests += 2;
      if (got_acc_q[0] !== -450) begin n_fail++; $display("FAIL neg_acc: got %0d required -450", got_acc_q[0]); end
      if (got_ovf_q[0] !== 1'b0) begin n_fail++; $display("FAIL neg_ovf: got %b required 0", got_ovf_q[0]); end
    end
  endtask

  task automatic test_random();
    int  sent;
    bit  hs, pv, pr;
    longint pa;
    clear_q();
    sent = 0;
    set_rand();
    for (int c = 0; c < 3000 && sent < 30; c++) begin
      in_valid[0] = ($urandom_range(0, 3) != 0);
      ot_ready[0] = ($urandom_range(0, 2) != 0);
      #1;
      hs = in_valid[0] && in_ready[0];
      pv = ot_valid[0]; pr = ot_ready[0]; pa = ot_acc[0];
      step();
      if (hs) begin sent++; set_rand(); end
      if (pv && !pr) begin
        n_tests++;
        if (ot_valid[0] !== 1'b1 || ot_acc[0] !== pa) begin
          n_fail++; $display("FAIL rand_hold: got valid %b acc %0d required 1 / %0d", ot_valid[0], ot_acc[0], pa);
        end
      end
    end
    ot_ready[0] = 1'b1;
    drain(0, 10, 40);
    for (int i = 0; i < got_acc_q.size() && i < exp_acc_q.size(); i++) begin
      n_tests++;
      if (got_acc_q[i] !== exp_acc_q[i] || got_ovf_q[i] !== exp_ovf_q[i]) begin
        n_fail++; $display("FAIL rand_result%0d: got %0d/%b required %0d/%b",
                           i, got_acc_q[i], got_ovf_q[i], exp_acc_q[i], exp_ovf_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int k;
    longint held;
    clear_q();
    for (int b = 0; b < 3; b++) begin set_rand(); send(0); end
    in_valid[0] = 1'b0;
    ot_ready[0] = 1'b0;
    k = 0;
    while (ot_valid[0] !== 1'b1 && k < 20) begin step(); k++; end
    held = ot_acc[0];
    set_rand();
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_tests += 2;
      if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %b required 0", i, in_ready[0]); end
      if (ot_valid[0] !== 1'b1 || ot_acc[0] !== held) begin
        n_fail++; $display("FAIL bp_hold%0d: got valid %b acc %0d required 1 / %0d", i, ot_valid[0], ot_acc[0], held);
      end
      step();
    end
    ot_ready[0] = 1'b1;
    send(0);
    for (int b = 0; b < 2; b++) begin set_rand(); send(0); end
    drain(0, 2, 20);
    for (int i = 0; i < got_acc_q.size() && i < exp_acc_q.size(); i++) begin
      n_tests++;
      if (got_acc_q[i] !== exp_acc_q[i] || got_ovf_q[i] !== exp_ovf_q[i]) begin
        n_fail++; $display("FAIL bp_result%0d: got %0d/%b required %0d/%b",
                           i, got_acc_q[i], got_ovf_q[i], exp_acc_q[i], exp_ovf_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_q();
    set_rand(); send(0);
    set_rand(); send(0);
    in_valid[0] = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_all(1, 1);
    repeat (3) send(0);
    drain(0, 1, 20);
    repeat (8) step();
    n_tests++;
    if (got_acc_q.size() != 1) begin n_fail++; $display("FAIL midrst_count: got %0d required 1", got_acc_q.size()); end
    if (got_acc_q.size() >= 1) begin
      n_tests++;
      if (got_acc_q[0] !== 75) begin n_fail++; $display("FAIL midrst_acc: got %0d required 75", got_acc_q[0]); end
    end
  endtask

  task automatic test_overflow();
    clear_q();
    set_all(524287, 127);
    repeat (3) send(1);
    drain(1, 1, 20);
    if (got_acc_q.size() == 1) begin
      n_tests += 2;
      if (got_ovf_q[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b required 1", got_ovf_q[0]); end
`ifdef STAGE2_KERNEL_SAT_EN
      if (got_acc_q[0] !== 32767) begin n_fail++; $display("FAIL ovf_acc: got %0d required 32767", got_acc_q[0]); end
`else
      if (got_acc_q[0] !== -9525) begin n_fail++; $display("FAIL ovf_acc: got %0d required -9525", got_acc_q[0]); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    for (int i = 0; i < 8; i++) begin
      set_all(2, (i % 2 == 0) ? 1 : -1);
      send(2);
    end
    drain(2, 8, 20);
    for (int i = 0; i < got_acc_q.size() && i < 8; i++) begin
      n_tests++;
      if (got_acc_q[i] !== ((i % 2 == 0) ? 50 : -50)) begin
        n_fail++; $display("FAIL b2b_result%0d: got %0d required %0d", i, got_acc_q[i], (i % 2 == 0) ? 50 : -50);
      end
      if (i > 0) begin
        n_tests++;
        if (gotcyc_q[i] - gotcyc_q[i-1] != 1) begin
          n_fail++; $display("FAIL b2b_spacing%0d: got %0d required 1", i, gotcyc_q[i] - gotcyc_q[i-1]);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    fmap = '0;
    weight = '0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      ot_ready[d] = 1'b1;
    end
    test_reset();
    test_ones();
    test_negative();
    test_random();
    test_backpressure();
    test_reset_midframe();
    test_overflow();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
